// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, with a registered carry between digits.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int          N     = WIDTH / DIGIT;
  localparam int          CW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW    = DIGIT;
  localparam logic [CW-1:0]    LAST  = CW'(N - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_err
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, last;
  int unsigned      base;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_ripple, c_msb;
  logic [WIDTH-1:0] sum_upd;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Full-adder ripple across the current digit; c_msb is the carry into the
  // top bit, which on the final digit is the carry into the word MSB.
  always_comb begin
    base     = 32'(cnt_q) * DW;
    a_dig    = DIGIT'(a_q >> base);
    b_dig    = DIGIT'(b_q >> base);
    s_dig    = '0;
    c_ripple = carry_q;
    c_msb    = 1'b0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (i == DW - 1) c_msb = c_ripple;
      s_dig[i] = a_dig[i] ^ b_dig[i] ^ c_ripple;
      c_ripple = (a_dig[i] & b_dig[i]) | (c_ripple & (a_dig[i] ^ b_dig[i]));
    end
    sum_upd = (sum_q & ~(DMASK << base)) | (WIDTH'(s_dig) << base);
  end

  // Subtraction is folded in at accept time: b is inverted and the borrow-in
  // becomes an inverted carry-in, so RUN only ever adds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b ^ {WIDTH{sub}};
      carry_q <= c_in ^ sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q   <= sum_upd;
      carry_q <= c_ripple;
      cnt_q   <= last ? '0 : cnt_q + 1'b1;
      if (last) begin
        cout_q <= c_ripple;
        ovf_q  <= c_msb ^ c_ripple;
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule
